mc_datapath: RTL and testbench
==============================

MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 Parameter DATA_W, 32, datapath, register and memory word width; legal values 16 to 64.
REQ-002 Parameter NREGS, 32, number of architectural registers; legal values 2 to 32.
REQ-003 Parameter DMEM_DEPTH, 64, data memory depth in words; must be a power of two.
REQ-004 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-high.
REQ-006 Port Instructions  in  32  instruction: [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm.
REQ-007 Ports RegDst, RegWr, ALUsrc, MemWr, MemToReg  in  1 each  control, same meaning as the single-cycle datapath.
REQ-008 Port ALUcntrl  in  2  ALU op: 00 add, 01 sub, 10 and, 11 or.
REQ-009 Port instr_valid  in  1  Instructions and control inputs are valid.
REQ-010 Port instr_ready  out  1  block can accept an instruction.
REQ-011 Port done  out  1  one-cycle pulse when an instruction retires.
REQ-012 Ports seOut  out  DATA_W, reg_Da  out  DATA_W, alu_out  out  DATA_W: sign-extended imm, latched rs value, latched ALU result.
REQ-013 Port Zero  out  1  latched ALU result equals zero.

Function
REQ-014 FSM states IDLE, RD, EX, MEM, WB; instr_ready SHALL be high exactly in IDLE.
REQ-015 Accept occurs on an edge with IDLE & instr_valid; Instructions and all control inputs are captured then and ignored until the next IDLE.
REQ-016 RD: latch A=R[rs], B=R[rt], seOut=sign-extend(imm) to DATA_W; reg_Da updates to A.
REQ-017 EX: alu_out = A op (ALUsrc ? seOut : B), modulo 2^DATA_W; Zero latched with it.
REQ-018 Transitions: EX->MEM if MemWr|MemToReg; else EX->WB if RegWr; else retire in EX.
REQ-019 MEM: word index = alu_out[log2(DMEM_DEPTH)+1:2], wrapping modulo DMEM_DEPTH; bits [1:0] ignored; MemWr writes B at end of MEM; sw retires in MEM; lw proceeds to WB.
REQ-020 WB: dest = RegDst ? rd : rt; data = MemToReg ? memory word : alu_out; retire in WB.
REQ-021 done SHALL be high during the retiring state's cycle only; the next state is IDLE.
REQ-022 Latency from accept edge to done: ALU-only no write 2 cycles, ALU with write 3, sw 3, lw 4.
REQ-023 Register 0 reads zero; writes to it are discarded; indices >= NREGS read zero and their writes are discarded.
REQ-024 Each write completes before the next accept, so back-to-back dependent instructions need no forwarding.

Reset
REQ-025 rst SHALL immediately force IDLE, clear all registers R[0..NREGS-1], and clear seOut, reg_Da, alu_out, Zero and done to 0.
REQ-026 rst mid-instruction SHALL abort it; no pending register or memory write occurs; data memory contents are not reset.

Configuration
REQ-027 Macro MC_DATAPATH_DBG_EN SHALL control the debug read port.
REQ-028 With the macro defined: ports dbg_addr in 5 and dbg_data out DATA_W are added; dbg_data = R[dbg_addr], combinational, zero for index 0 or any index >= NREGS.
REQ-029 Without the macro: the debug ports are absent and the block has no debug logic.

Structure
REQ-030 Package datapath_pkg SHALL hold the ALU-op enum, the FSM state enum, and the field-position constants of the instruction word.
REQ-031 Sub-module mc_regfile SHALL implement the register file: two asynchronous read ports, one synchronous write port, async clear, and the debug read port when enabled.

Verification
REQ-032 addi $1,$0,2015 then addi $2,$0,404 -> R1=2015, R2=404; each done occurs 3 cycles after its accept.
REQ-033 add $1,$1,$2 issued back-to-back after the addis -> R1=2419, Zero=0.
REQ-034 sw $2,0($0) then lw $3,0($0) -> memory word 0 = 404 with done 3 cycles after accept; then R3=404 with done 4 cycles after accept.
REQ-035 sub $4,$1,$1 -> alu_out=0, Zero=1; addi $0,$0,5 -> R0 reads 0; Instructions changed while busy -> no effect on the result.
REQ-036 rst asserted during MEM of sw $2,4($0) -> FSM goes to IDLE immediately, memory word 1 is unchanged, all registers read 0, instr_ready=1.
REQ-037 sw to byte address 4*DMEM_DEPTH -> memory word 0 is written (wrap-around); with MC_DATAPATH_DBG_EN defined, dbg_addr=2 -> dbg_data=404.

Source files
------------

// File: rtl/datapath_pkg.sv
// -----------------------------------------------------------------------------
// datapath_pkg
// Shared definitions for the multi-cycle datapath slice:
//   - alu_op_e  : ALU operation encoding carried on ALUcntrl
//   - state_e   : controller states IDLE -> RD -> EX -> (MEM) -> (WB)
//   - instruction-word field positions (rs / rt / rd / imm)
//   - reg_idx_ok: says whether a register index refers to a writable/readable
//                 architectural register (index 0 and indices >= nregs are not)
// -----------------------------------------------------------------------------
package datapath_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4
    } state_e;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned RS_MSB  = 25;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_MSB  = 20;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned RD_MSB  = 15;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    // Register 0 is hard-wired to zero and indices beyond the file do not exist.
    function automatic logic reg_idx_ok(input logic [REG_AW-1:0] idx,
                                        input int unsigned        nregs);
        return (idx != 5'd0) && (32'(idx) < nregs);
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// -----------------------------------------------------------------------------
// mc_regfile
// Architectural register file: two asynchronous read ports, one synchronous
// write port, asynchronous clear of every register on rst.
// Register 0 and indices >= NREGS read as zero and ignore writes.
// Optional feature macro: MC_DATAPATH_DBG_EN adds a combinational debug read
// port (dbg_addr / dbg_data) with the same zero rules.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ra_addr / ra_data   read port A
//   rb_addr / rb_data   read port B
//   we, wa, wd          write enable, write index, write data
//   dbg_addr, dbg_data  debug read port (MC_DATAPATH_DBG_EN only)
// -----------------------------------------------------------------------------
module mc_regfile
    import datapath_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
`ifdef MC_DATAPATH_DBG_EN
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
`endif
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    // Full 32-entry array so any 5-bit index is in range; entries at or above
    // NREGS are never written and therefore stay at their cleared value.
    logic [DATA_W-1:0] regs_r [32];

    // Register storage: async clear, guarded synchronous write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= '0;
            end
        end else if (we && reg_idx_ok(wa, NREGS)) begin
            regs_r[wa] <= wd;
        end
    end

    // Asynchronous read ports A and B.
    always_comb begin
        if (reg_idx_ok(ra_addr, NREGS)) begin
            ra_data = regs_r[ra_addr];
        end else begin
            ra_data = '0;
        end
        if (reg_idx_ok(rb_addr, NREGS)) begin
            rb_data = regs_r[rb_addr];
        end else begin
            rb_data = '0;
        end
    end

`ifdef MC_DATAPATH_DBG_EN
    // Debug read port.
    always_comb begin
        if (reg_idx_ok(dbg_addr, NREGS)) begin
            dbg_data = regs_r[dbg_addr];
        end else begin
            dbg_data = '0;
        end
    end
`endif

endmodule

// File: rtl/mc_datapath.sv
// -----------------------------------------------------------------------------
// mc_datapath
// Multi-cycle MIPS-style datapath. An instruction plus its control bits is
// accepted in IDLE and then walks RD -> EX -> (MEM) -> (WB); done pulses in the
// cycle of the state in which it retires, after which the block is IDLE again.
// Register writes land at the end of WB, so the next accepted instruction sees
// them without forwarding. Data memory is not cleared by reset.
// Optional feature macro: MC_DATAPATH_DBG_EN adds dbg_addr / dbg_data.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   Instructions[31:0]           [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm
//   RegDst RegWr ALUsrc MemWr MemToReg, ALUcntrl[1:0]   control inputs
//   instr_valid / instr_ready    accept handshake (ready high only in IDLE)
//   done                         one-cycle retire pulse
//   seOut, reg_Da, alu_out, Zero latched sign-extended imm, rs value, ALU result
//   dbg_addr, dbg_data           debug register read (MC_DATAPATH_DBG_EN only)
// -----------------------------------------------------------------------------
module mc_datapath
    import datapath_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NREGS      = 32,
    parameter int DMEM_DEPTH = 64
) (
`ifdef MC_DATAPATH_DBG_EN
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
`endif
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       Instructions,
    input  logic              RegDst,
    input  logic              RegWr,
    input  logic              ALUsrc,
    input  logic              MemWr,
    input  logic              MemToReg,
    input  logic [1:0]        ALUcntrl,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              done,
    output logic [DATA_W-1:0] seOut,
    output logic [DATA_W-1:0] reg_Da,
    output logic [DATA_W-1:0] alu_out,
    output logic              Zero
);

    localparam int AW = $clog2(DMEM_DEPTH);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [25:0]       instr_r;
    logic              regdst_r;
    logic              regwr_r;
    logic              alusrc_r;
    logic              memwr_r;
    logic              memtoreg_r;
    alu_op_e           aluop_r;
    logic [DATA_W-1:0] b_r;

    logic              accept_s;
    logic              latch_rd_s;
    logic              latch_ex_s;
    logic              mem_we_s;
    logic              reg_we_s;
    logic              done_nxt_s;
    logic              ready_nxt_s;

    logic [DATA_W-1:0] ra_data_s;
    logic [DATA_W-1:0] rb_data_s;
    logic [DATA_W-1:0] se_s;
    logic [DATA_W-1:0] opb_s;
    logic [DATA_W-1:0] alu_res_s;
    logic [REG_AW-1:0] wa_s;
    logic [DATA_W-1:0] wd_s;

    logic [DATA_W-1:0] dmem_r [DMEM_DEPTH];
    logic [AW-1:0]     dmem_idx_s;
    logic [DATA_W-1:0] dmem_q_s;

    // Opcode bits are not decoded; control comes in on the dedicated inputs.
    logic              opcode_unused_s;
    assign opcode_unused_s = ^Instructions[31:26];

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (instr_valid) begin
                    state_nxt_s = ST_RD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD: state_nxt_s = ST_EX;
            ST_EX: begin
                if (memwr_r || memtoreg_r) begin
                    state_nxt_s = ST_MEM;
                end else if (regwr_r) begin
                    state_nxt_s = ST_WB;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MEM: begin
                if (memtoreg_r) begin
                    state_nxt_s = ST_WB;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WB:   state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: datapath strobes plus the next values of done/instr_ready.
    // done is registered, so it is set on the edge that enters the state in
    // which the instruction retires.
    always_comb begin
        accept_s    = (state_r == ST_IDLE) && instr_valid;
        latch_rd_s  = (state_r == ST_RD);
        latch_ex_s  = (state_r == ST_EX);
        mem_we_s    = (state_r == ST_MEM) && memwr_r;
        reg_we_s    = (state_r == ST_WB) && regwr_r;
        ready_nxt_s = (state_nxt_s == ST_IDLE);
        case (state_nxt_s)
            ST_EX:   done_nxt_s = !(memwr_r || memtoreg_r || regwr_r);
            ST_MEM:  done_nxt_s = !memtoreg_r;
            ST_WB:   done_nxt_s = 1'b1;
            default: done_nxt_s = 1'b0;
        endcase
    end

    // Sign extension of the captured immediate.
    always_comb begin
        se_s = DATA_W'($signed(instr_r[IMM_MSB:IMM_LSB]));
    end

    // ALU: operand B selects between sign-extended immediate and rt value.
    always_comb begin
        if (alusrc_r) begin
            opb_s = seOut;
        end else begin
            opb_s = b_r;
        end
        case (aluop_r)
            ALU_ADD: alu_res_s = reg_Da + opb_s;
            ALU_SUB: alu_res_s = reg_Da - opb_s;
            ALU_AND: alu_res_s = reg_Da & opb_s;
            ALU_OR:  alu_res_s = reg_Da | opb_s;
            default: alu_res_s = '0;
        endcase
    end

    // Write-back destination and data selection.
    always_comb begin
        if (regdst_r) begin
            wa_s = instr_r[RD_MSB:RD_LSB];
        end else begin
            wa_s = instr_r[RT_MSB:RT_LSB];
        end
        if (memtoreg_r) begin
            wd_s = dmem_q_s;
        end else begin
            wd_s = alu_out;
        end
    end

    // Instruction capture and datapath pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_r     <= 26'd0;
            regdst_r    <= 1'b0;
            regwr_r     <= 1'b0;
            alusrc_r    <= 1'b0;
            memwr_r     <= 1'b0;
            memtoreg_r  <= 1'b0;
            aluop_r     <= ALU_ADD;
            b_r         <= '0;
            seOut       <= '0;
            reg_Da      <= '0;
            alu_out     <= '0;
            Zero        <= 1'b0;
            done        <= 1'b0;
            instr_ready <= 1'b1;
        end else begin
            done        <= done_nxt_s;
            instr_ready <= ready_nxt_s;
            if (accept_s) begin
                instr_r    <= Instructions[25:0];
                regdst_r   <= RegDst;
                regwr_r    <= RegWr;
                alusrc_r   <= ALUsrc;
                memwr_r    <= MemWr;
                memtoreg_r <= MemToReg;
                aluop_r    <= alu_op_e'(ALUcntrl);
            end
            if (latch_rd_s) begin
                reg_Da <= ra_data_s;
                b_r    <= rb_data_s;
                seOut  <= se_s;
            end
            if (latch_ex_s) begin
                alu_out <= alu_res_s;
                Zero    <= (alu_res_s == {DATA_W{1'b0}});
            end
        end
    end

    // Word index ignores the byte offset and wraps modulo the memory depth.
    assign dmem_idx_s = alu_out[AW+1:2];
    assign dmem_q_s   = dmem_r[dmem_idx_s];

    // Data memory write; contents survive reset, and a reset edge never writes.
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
            dmem_r[dmem_idx_s] <= b_r;
        end
    end

    mc_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
`ifdef MC_DATAPATH_DBG_EN
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
`endif
        .clk      (clk),
        .rst      (rst),
        .ra_addr  (instr_r[RS_MSB:RS_LSB]),
        .ra_data  (ra_data_s),
        .rb_addr  (instr_r[RT_MSB:RT_LSB]),
        .rb_data  (rb_data_s),
        .we       (reg_we_s),
        .wa       (wa_s),
        .wd       (wd_s)
    );

endmodule

// File: tb/tb_mc_datapath.sv
// -----------------------------------------------------------------------------
// tb_mc_datapath
// Scoreboard bench for mc_datapath: each issued instruction pushes its
// expected latency / ALU result / Zero / seOut / reg_Da (from a small register
// and memory model) and the entry is popped and compared when done pulses.
// Register contents are observed by "probe" instructions (or $0,$rs,$0 with no
// write) whose latched reg_Da is compared to a fixed expected constant.
// -----------------------------------------------------------------------------
module tb_mc_datapath;
    import datapath_pkg::*;

    localparam int DATA_W     = 32;
    localparam int NREGS      = 32;
    localparam int DMEM_DEPTH = 64;

    typedef struct packed {
        logic       regdst;
        logic       regwr;
        logic       alusrc;
        logic       memwr;
        logic       memtoreg;
        logic [1:0] op;
    } ctrl_t;

    localparam ctrl_t C_ADDI  = '{regdst:1'b0, regwr:1'b1, alusrc:1'b1, memwr:1'b0, memtoreg:1'b0, op:2'b00};
    localparam ctrl_t C_ADD   = '{regdst:1'b1, regwr:1'b1, alusrc:1'b0, memwr:1'b0, memtoreg:1'b0, op:2'b00};
    localparam ctrl_t C_SUB   = '{regdst:1'b1, regwr:1'b1, alusrc:1'b0, memwr:1'b0, memtoreg:1'b0, op:2'b01};
    localparam ctrl_t C_AND   = '{regdst:1'b1, regwr:1'b1, alusrc:1'b0, memwr:1'b0, memtoreg:1'b0, op:2'b10};
    localparam ctrl_t C_ORNW  = '{regdst:1'b1, regwr:1'b0, alusrc:1'b0, memwr:1'b0, memtoreg:1'b0, op:2'b11};
    localparam ctrl_t C_SW    = '{regdst:1'b0, regwr:1'b0, alusrc:1'b1, memwr:1'b1, memtoreg:1'b0, op:2'b00};
    localparam ctrl_t C_LW    = '{regdst:1'b0, regwr:1'b1, alusrc:1'b1, memwr:1'b0, memtoreg:1'b1, op:2'b00};

    typedef struct {
        int          lat;
        logic [31:0] alu;
        logic        zero;
        logic [31:0] se;
        logic [31:0] rda;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       Instructions = 32'd0;
    logic              RegDst = 1'b0;
    logic              RegWr = 1'b0;
    logic              ALUsrc = 1'b0;
    logic              MemWr = 1'b0;
    logic              MemToReg = 1'b0;
    logic [1:0]        ALUcntrl = 2'b00;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic              done;
    logic [DATA_W-1:0] seOut;
    logic [DATA_W-1:0] reg_Da;
    logic [DATA_W-1:0] alu_out;
    logic              Zero;
`ifdef MC_DATAPATH_DBG_EN
    logic [4:0]        dbg_addr = 5'd0;
    logic [DATA_W-1:0] dbg_data;
`endif

    int          checks = 0;
    int          failures = 0;
    exp_t        sb_q[$];
    string       tag_q[$];
    logic [31:0] m_reg [32];
    logic [31:0] m_mem [DMEM_DEPTH];

    always #5 clk = ~clk;

    mc_datapath #(
        .DATA_W     (DATA_W),
        .NREGS      (NREGS),
        .DMEM_DEPTH (DMEM_DEPTH)
    ) dut (
`ifdef MC_DATAPATH_DBG_EN
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data),
`endif
        .clk          (clk),
        .rst          (rst),
        .Instructions (Instructions),
        .RegDst       (RegDst),
        .RegWr        (RegWr),
        .ALUsrc       (ALUsrc),
        .MemWr        (MemWr),
        .MemToReg     (MemToReg),
        .ALUcntrl     (ALUcntrl),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .done         (done),
        .seOut        (seOut),
        .reg_Da       (reg_Da),
        .alu_out      (alu_out),
        .Zero         (Zero)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] i_type(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {6'd0, rs, rt, imm};
    endfunction

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 11'd0};
    endfunction

    task automatic scramble_inputs();
        Instructions = $urandom;
        RegDst       = 1'($urandom);
        RegWr        = 1'($urandom);
        ALUsrc       = 1'($urandom);
        MemWr        = 1'($urandom);
        MemToReg     = 1'($urandom);
        ALUcntrl     = 2'($urandom);
    endtask

    // Wait (bounded) for instr_ready at a falling edge, then present one instruction.
    task automatic drive(input string tag, input logic [31:0] ins, input ctrl_t c);
        int w;
        w = 0;
        @(negedge clk);
        while (!instr_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_val({tag, "_ready"}, 64'(instr_ready), 64'd1);
        Instructions = ins;
        RegDst       = c.regdst;
        RegWr        = c.regwr;
        ALUsrc       = c.alusrc;
        MemWr        = c.memwr;
        MemToReg     = c.memtoreg;
        ALUcntrl     = c.op;
        instr_valid  = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        scramble_inputs();
    endtask

    // Model the instruction, push its expectation, run it, then pop and compare.
    task automatic issue(input string tag, input logic [31:0] ins, input ctrl_t c,
                         input logic use_const, input logic [31:0] rda_const);
        exp_t        e;
        exp_t        got;
        string       t;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] opb;
        logic [31:0] res;
        logic [4:0]  dst;
        logic [5:0]  idx;
        logic        wb;
        int          cyc;
        logic        seen;

        a    = m_reg[ins[25:21]];
        b    = m_reg[ins[20:16]];
        e.se = {{16{ins[15]}}, ins[15:0]};
        opb  = c.alusrc ? e.se : b;
        case (c.op)
            2'b00:   res = a + opb;
            2'b01:   res = a - opb;
            2'b10:   res = a & opb;
            default: res = a | opb;
        endcase
        e.alu  = res;
        e.zero = (res == 32'd0);
        e.rda  = use_const ? rda_const : a;
        if (c.memwr || c.memtoreg) begin
            e.lat = c.memtoreg ? 4 : 3;
        end else begin
            e.lat = c.regwr ? 3 : 2;
        end
        idx = res[7:2];
        if (c.memwr) begin
            m_mem[idx] = b;
        end
        wb  = c.memtoreg || (!c.memwr && c.regwr);
        dst = c.regdst ? ins[15:11] : ins[20:16];
        if (wb && c.regwr && dst != 5'd0) begin
            m_reg[dst] = c.memtoreg ? m_mem[idx] : res;
        end
        sb_q.push_back(e);
        tag_q.push_back(tag);

        drive(tag, ins, c);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1'b1;
            end else begin
                check_val({tag, "_busy_ready"}, 64'(instr_ready), 64'd0);
            end
        end
        got = sb_q.pop_front();
        t   = tag_q.pop_front();
        check_val({t, "_done_seen"}, 64'(seen), 64'd1);
        check_val({t, "_latency"}, 64'(cyc), 64'(got.lat));
        @(negedge clk);
        check_val({t, "_done_pulse"}, 64'(done), 64'd0);
        check_val({t, "_idle_ready"}, 64'(instr_ready), 64'd1);
        check_val({t, "_alu_out"}, 64'(alu_out), 64'(got.alu));
        check_val({t, "_zero"}, 64'(Zero), 64'(got.zero));
        check_val({t, "_seout"}, 64'(seOut), 64'(got.se));
        check_val({t, "_reg_da"}, 64'(reg_Da), 64'(got.rda));
    endtask

    task automatic probe(input string tag, input logic [4:0] r, input logic [31:0] exp_val);
        issue(tag, r_type(r, 5'd0, 5'd0), C_ORNW, 1'b1, exp_val);
    endtask

    task automatic run(input string tag, input logic [31:0] ins, input ctrl_t c);
        issue(tag, ins, c, 1'b0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        for (int i = 0; i < DMEM_DEPTH; i++) m_mem[i] = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", 64'(instr_ready), 64'd1);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_alu_out", 64'(alu_out), 64'd0);
        check_val("rst_seout", 64'(seOut), 64'd0);
        check_val("rst_reg_da", 64'(reg_Da), 64'd0);
        check_val("rst_zero", 64'(Zero), 64'd0);
        rst = 1'b0;

        // Immediate adds, then read back
        run("addi_r1", i_type(5'd0, 5'd1, 16'd2015), C_ADDI);
        run("addi_r2", i_type(5'd0, 5'd2, 16'd404), C_ADDI);
        probe("probe_r1_2015", 5'd1, 32'd2015);
        probe("probe_r2_404", 5'd2, 32'd404);

        // Dependent R-type add
        run("add_r1", r_type(5'd1, 5'd2, 5'd1), C_ADD);
        probe("probe_r1_2419", 5'd1, 32'd2419);

        // Store / load round trip
        run("sw_w0", i_type(5'd0, 5'd2, 16'd0), C_SW);
        run("lw_r3", i_type(5'd0, 5'd3, 16'd0), C_LW);
        probe("probe_r3_404", 5'd3, 32'd404);

        // Subtract to zero, write to R0 discarded
        run("sub_r4", r_type(5'd1, 5'd1, 5'd4), C_SUB);
        probe("probe_r4_0", 5'd4, 32'd0);
        run("addi_r0", i_type(5'd0, 5'd0, 16'd5), C_ADDI);
        probe("probe_r0_0", 5'd0, 32'd0);

        // Logic ops and negative immediate
        run("and_r7", r_type(5'd1, 5'd2, 5'd7), C_AND);
        probe("probe_r7_272", 5'd7, 32'd272);
        run("or_nowrite", r_type(5'd1, 5'd2, 5'd8), C_ORNW);
        run("addi_neg_r9", i_type(5'd1, 5'd9, 16'hFFED), C_ADDI);
        probe("probe_r9_2400", 5'd9, 32'd2400);

        // Address wrap: byte 4*DMEM_DEPTH maps to word 0
        run("sw_wrap", i_type(5'd0, 5'd1, 16'(4 * DMEM_DEPTH)), C_SW);
        run("lw_r6", i_type(5'd0, 5'd6, 16'd0), C_LW);
        probe("probe_r6_2419", 5'd6, 32'd2419);

`ifdef MC_DATAPATH_DBG_EN
        dbg_addr = 5'd2;
        #1;
        check_val("dbg_r2", 64'(dbg_data), 64'd404);
        dbg_addr = 5'd0;
        #1;
        check_val("dbg_r0", 64'(dbg_data), 64'd0);
`endif

        // Reset during MEM of a store must abort it
        run("sw_w1", i_type(5'd0, 5'd1, 16'd4), C_SW);
        drive("sw_abort", i_type(5'd0, 5'd2, 16'd4), C_SW);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_val("abort_in_mem_ready", 64'(instr_ready), 64'd0);
        rst = 1'b1;
        #1;
        check_val("abort_ready", 64'(instr_ready), 64'd1);
        check_val("abort_done", 64'(done), 64'd0);
        check_val("abort_alu_out", 64'(alu_out), 64'd0);
        check_val("abort_reg_da", 64'(reg_Da), 64'd0);
        check_val("abort_seout", 64'(seOut), 64'd0);
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        probe("post_rst_r1", 5'd1, 32'd0);
        probe("post_rst_r2", 5'd2, 32'd0);
        run("lw_r5", i_type(5'd0, 5'd5, 16'd4), C_LW);
        probe("probe_r5_2419", 5'd5, 32'd2419);

        check_val("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
